// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, issues single-outstanding
// memory reads and buffers returned words in a small queue toward IF/ID.
module ifu_fetch_ctrl #(
   parameter int unsigned     XLEN     = 64,
   parameter int unsigned     INST_LEN = 32,
   parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000,
   parameter int unsigned     DEPTH    = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                redirect_valid_i,
   input  logic [XLEN-1:0]     redirect_pc_i,
   output logic                mem_req_valid_o,
   input  logic                mem_req_ready_i,
   output logic [XLEN-1:0]     mem_req_addr_o,
   input  logic                mem_rsp_valid_i,
   input  logic [INST_LEN-1:0] mem_rsp_data_i,
   output logic                inst_valid_o,
   input  logic                inst_ready_i,
   output logic [XLEN-1:0]     inst_addr_o,
   output logic [INST_LEN-1:0] inst_data_o
);

   localparam int unsigned   PW      = $clog2(DEPTH);
   localparam int unsigned   CW      = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DROP = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [XLEN-1:0]     fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]     req_addr_q, req_addr_d;
   logic                pend_q, pend_d;
   logic [CW-1:0]       count_q, count_d;
   logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [XLEN-1:0]     addr_mem_q [DEPTH];
   logic [INST_LEN-1:0] data_mem_q [DEPTH];

   logic                handshake;
   logic                push;
   logic                pop;
   logic [XLEN-1:0]     redirect_pc_aligned;

   assign handshake           = (state_q == ST_REQ) && mem_req_ready_i;
   // A redirect flushes the queue, so a same-cycle response or pop is moot.
   assign push                = (state_q == ST_WAIT) && mem_rsp_valid_i && !redirect_valid_i;
   assign pop                 = (count_q != '0) && inst_ready_i && !redirect_valid_i;
   assign redirect_pc_aligned = redirect_pc_i & ~XLEN'(3);

   always_comb begin
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (redirect_valid_i) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !pop)      count_d = count_q + 1'b1;
         else if (pop && !push) count_d = count_q - 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_addr_d = req_addr_q;
      pend_d     = pend_q;
      case (state_q)
         ST_IDLE: begin
            if (!redirect_valid_i && (count_q < DEPTH_C)) begin
               req_addr_d = fetch_pc_q;
               state_d    = ST_REQ;
            end
         end
         ST_REQ: begin
            // The request is held until accepted; a redirect only marks it stale.
            if (handshake) begin
               pend_d = 1'b0;
               if (redirect_valid_i || pend_q) begin
                  state_d = ST_DROP;
               end else begin
                  fetch_pc_d = req_addr_q + XLEN'(4);
                  state_d    = ST_WAIT;
               end
            end else if (redirect_valid_i) begin
               pend_d = 1'b1;
            end
         end
         ST_WAIT: begin
            if (mem_rsp_valid_i) begin
               if (!redirect_valid_i && (count_d < DEPTH_C)) begin
                  req_addr_d = fetch_pc_q;
                  state_d    = ST_REQ;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (redirect_valid_i) begin
               state_d = ST_DROP;
            end
         end
         ST_DROP: begin
            if (mem_rsp_valid_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (redirect_valid_i) fetch_pc_d = redirect_pc_aligned;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         fetch_pc_q <= RESET_PC;
         req_addr_q <= '0;
         pend_q     <= 1'b0;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_addr_q <= req_addr_d;
         pend_q     <= pend_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   // Storage is cleared on reset so the head outputs read zero while in reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            addr_mem_q[i] <= '0;
            data_mem_q[i] <= '0;
         end
      end else if (push) begin
         addr_mem_q[wr_ptr_q] <= req_addr_q;
         data_mem_q[wr_ptr_q] <= mem_rsp_data_i;
      end
   end

   assign mem_req_valid_o = (state_q == ST_REQ);
   assign mem_req_addr_o  = req_addr_q;
   assign inst_valid_o    = (count_q != '0);
   assign inst_addr_o     = addr_mem_q[rd_ptr_q];
   assign inst_data_o     = data_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Randomized scoreboard bench for ifu_fetch_ctrl: a memory model answers
// accepted requests, a reference model tracks which words must reach IF/ID.
module tb_ifu_fetch_ctrl;
   localparam int unsigned XLEN     = 64;
   localparam int unsigned INST_LEN = 32;
   localparam int unsigned DEPTH    = 2;
   localparam logic [63:0] RESET_PC = 64'h8000_0000;

   logic        clk;
   logic        rst;
   logic        redirect_valid_i;
   logic [63:0] redirect_pc_i;
   logic        mem_req_valid_o;
   logic        mem_req_ready_i;
   logic [63:0] mem_req_addr_o;
   logic        mem_rsp_valid_i;
   logic [31:0] mem_rsp_data_i;
   logic        inst_valid_o;
   logic        inst_ready_i;
   logic [63:0] inst_addr_o;
   logic [31:0] inst_data_o;

   ifu_fetch_ctrl #(
      .XLEN     (XLEN),
      .INST_LEN (INST_LEN),
      .RESET_PC (RESET_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .redirect_valid_i (redirect_valid_i),
      .redirect_pc_i    (redirect_pc_i),
      .mem_req_valid_o  (mem_req_valid_o),
      .mem_req_ready_i  (mem_req_ready_i),
      .mem_req_addr_o   (mem_req_addr_o),
      .mem_rsp_valid_i  (mem_rsp_valid_i),
      .mem_rsp_data_i   (mem_rsp_data_i),
      .inst_valid_o     (inst_valid_o),
      .inst_ready_i     (inst_ready_i),
      .inst_addr_o      (inst_addr_o),
      .inst_data_o      (inst_data_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] addr;
      logic [31:0] data;
   } ent_t;

   typedef struct packed {
      logic [63:0] addr;
      int          due;
      bit          live;
   } rsp_t;

   // Reference model state
   ent_t        sb[$];        // words IF/ID must still receive, in order
   rsp_t        rsp_q[$];     // accepted requests awaiting a memory response
   logic [63:0] next_pc   = RESET_PC;
   bit          cur_stale = 1'b0;
   bit          prev_vld  = 1'b0;
   logic [63:0] prev_addr = '0;
   int          cyc       = 0;
   int          n_tests   = 0;
   int          n_fail    = 0;
   int          n_pops    = 0;

   // Stimulus knobs (percentages)
   int p_rdy   = 0;
   int p_irdy  = 0;
   int p_redir = 0;
   int max_dly = 1;
   bit mon_en  = 1'b0;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return a[31:0] ^ a[63:32] ^ {a[17:2], 16'hC3A5};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      sb.delete();
      rsp_q.delete();
      next_pc   = RESET_PC;
      cur_stale = 1'b0;
      prev_vld  = 1'b0;
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_mem_req_vld"}, 64'(mem_req_valid_o), 64'd0);
      chk({tag, "_mem_req_addr"}, mem_req_addr_o, 64'd0);
      chk({tag, "_inst_vld"}, 64'(inst_valid_o), 64'd0);
      chk({tag, "_inst_addr"}, inst_addr_o, 64'd0);
      chk({tag, "_inst_data"}, 64'(inst_data_o), 64'd0);
   endtask

   // Driver: inputs change 1 time unit after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (!rst) begin
            mem_req_ready_i  = 1'b0;
            inst_ready_i     = 1'b0;
            redirect_valid_i = 1'b0;
            mem_rsp_valid_i  = 1'b0;
         end else begin
            mem_req_ready_i  = (int'($urandom_range(99)) < p_rdy);
            inst_ready_i     = (int'($urandom_range(99)) < p_irdy);
            redirect_valid_i = (int'($urandom_range(99)) < p_redir);
            case ($urandom_range(3))
               0:       redirect_pc_i = 64'h0000_0000_8000_1002;
               1:       redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFF6;
               2:       redirect_pc_i = {32'h0, $urandom};
               default: redirect_pc_i = {$urandom, $urandom};
            endcase
            if (rsp_q.size() != 0 && cyc >= rsp_q[0].due) begin
               mem_rsp_valid_i = 1'b1;
               mem_rsp_data_i  = mem_word(rsp_q[0].addr);
            end else begin
               mem_rsp_valid_i = 1'b0;
               mem_rsp_data_i  = $urandom;
            end
         end
      end
   end

   // Monitor / scoreboard: samples every falling edge.
   initial begin
      bit   redir;
      bit   acc;
      int   sz;
      rsp_t r;
      ent_t e;
      forever begin
         @(negedge clk);
         if (rst && mon_en) begin
            redir = redirect_valid_i;
            acc   = mem_req_valid_o && mem_req_ready_i;
            sz    = sb.size();

            chk("inst_valid", 64'(inst_valid_o), 64'(sz != 0));
            if (sz != 0) begin
               chk("inst_addr", inst_addr_o, sb[0].addr);
               chk("inst_data", 64'(inst_data_o), 64'(sb[0].data));
            end

            // A request touched by a redirect between first valid and acceptance is stale.
            if (prev_vld) begin
               chk("req_hold_vld", 64'(mem_req_valid_o), 64'd1);
               chk("req_hold_addr", mem_req_addr_o, prev_addr);
            end else if (mem_req_valid_o) begin
               cur_stale = 1'b0;
            end
            if (mem_req_valid_o && redir) cur_stale = 1'b1;

            if (acc) begin
               if (!cur_stale) begin
                  chk("req_addr", mem_req_addr_o, next_pc);
                  chk("req_credit", 64'(sz < int'(DEPTH)), 64'd1);
                  next_pc = next_pc + 64'd4;
               end
               chk("single_outstanding", 64'(rsp_q.size()), 64'd0);
               r.addr = mem_req_addr_o;
               r.due  = cyc + int'($urandom_range(max_dly, 1));
               r.live = !cur_stale;
               rsp_q.push_back(r);
            end
            prev_vld  = mem_req_valid_o && !acc;
            prev_addr = mem_req_addr_o;

            if (inst_valid_o && inst_ready_i && !redir && sz != 0) begin
               void'(sb.pop_front());
               n_pops++;
            end

            if (mem_rsp_valid_i && rsp_q.size() != 0) begin
               r = rsp_q.pop_front();
               if (r.live && !redir) begin
                  e.addr = r.addr;
                  e.data = mem_word(r.addr);
                  sb.push_back(e);
               end
            end

            if (redir) begin
               sb.delete();
               next_pc = {redirect_pc_i[63:2], 2'b00};
               foreach (rsp_q[i]) rsp_q[i].live = 1'b0;
            end
         end
      end
   end

   initial begin
      bit found;
      rst              = 1'b0;
      redirect_valid_i = 1'b0;
      redirect_pc_i    = '0;
      mem_req_ready_i  = 1'b0;
      mem_rsp_valid_i  = 1'b0;
      mem_rsp_data_i   = '0;
      inst_ready_i     = 1'b0;

      repeat (3) @(negedge clk);
      chk_outputs_zero("reset");

      // Zero-wait memory, IF/ID always ready
      p_rdy = 100; p_irdy = 100; p_redir = 0; max_dly = 1;
      #1;
      model_reset();
      rst    = 1'b1;
      mon_en = 1'b1;
      @(posedge clk);
      #2;
      chk("first_req_vld", 64'(mem_req_valid_o), 64'd1);
      chk("first_req_addr", mem_req_addr_o, RESET_PC);
      repeat (20) @(negedge clk);

      // IF/ID stalls: queue fills to capacity and fetch stops
      p_irdy = 0;
      repeat (12) @(negedge clk);
      #1;
      chk("full_no_req", 64'(mem_req_valid_o), 64'd0);
      chk("full_inst_vld", 64'(inst_valid_o), 64'd1);

      // Randomized traffic with redirects and variable latency
      p_rdy = 70; p_irdy = 70; p_redir = 6; max_dly = 3;
      repeat (3000) @(negedge clk);

      // Drain, then catch WAIT with one entry queued and reset there
      p_redir = 0; p_rdy = 0; p_irdy = 100;
      repeat (15) @(negedge clk);
      p_rdy = 100; p_irdy = 0; max_dly = 3;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         #1;
         if (!mem_req_valid_o && inst_valid_o && !mem_rsp_valid_i && rsp_q.size() != 0)
            found = 1'b1;
      end
      chk("reach_wait_with_entry", 64'(found), 64'd1);
      #1;
      rst    = 1'b0;
      mon_en = 1'b0;
      #1;
      chk_outputs_zero("midrst");
      model_reset();
      repeat (2) @(negedge clk);
      p_rdy = 100; p_irdy = 80; p_redir = 0; max_dly = 1;
      #1;
      rst    = 1'b1;
      mon_en = 1'b1;
      @(posedge clk);
      #2;
      chk("restart_req_vld", 64'(mem_req_valid_o), 64'd1);
      chk("restart_req_addr", mem_req_addr_o, RESET_PC);

      // Fast memory, frequent redirects
      p_redir = 10;
      repeat (1000) @(negedge clk);

      // Final drain: memory stops accepting, IF/ID empties the queue
      p_redir = 0; p_rdy = 0; p_irdy = 100;
      repeat (20) @(negedge clk);
      #1;
      chk("drain_inst_vld", 64'(inst_valid_o), 64'd0);
      chk("drain_outstanding", 64'(rsp_q.size()), 64'd0);
      chk("progress", 64'(n_pops > 100), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ifu_fetch_ctrl.md
# ifu_fetch_ctrl

Instruction-fetch controller that sits directly upstream of the IF/ID pipeline register. It owns the fetch PC, issues single-outstanding read requests to instruction memory over a valid/ready handshake, and buffers returned instructions in a small queue. The queue feeds IF/ID through a valid/ready interface. Redirects from branch, jump and trap logic flush the queue and discard any in-flight response.

## Interface
Parameters:
- XLEN, 64, address/PC width
- INST_LEN, 32, instruction width
- RESET_PC, 64'h8000_0000, first fetch address after reset
- DEPTH, 2, instruction queue entries (power of two, ≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous assert, active-low (0 = reset)
- redirect_valid_i  in  1  flush and restart fetch
- redirect_pc_i  in  XLEN  new fetch address
- mem_req_valid_o  out  1  read request valid
- mem_req_ready_i  in  1  memory accepts request
- mem_req_addr_o  out  XLEN  request address, word aligned
- mem_rsp_valid_i  in  1  read data valid; always accepted
- mem_rsp_data_i  in  INST_LEN  instruction word
- inst_valid_o  out  1  queue head valid toward IF/ID
- inst_ready_i  in  1  IF/ID consumes head
- inst_addr_o  out  XLEN  PC of head instruction
- inst_data_o  out  INST_LEN  head instruction

## Operation
- Registers:
  - fetch_pc: next address to request.
  - req_addr: address of the current or outstanding request.
  - 2-bit FSM.
  - Queue of DEPTH entries {addr, data} with read/write pointers and count.
- States:
  - IDLE: if credit is available, load req_addr ← fetch_pc and go to REQ.
  - REQ: mem_req_valid_o=1, mem_req_addr_o=req_addr. On mem_req_ready_i, fetch_pc ← req_addr+4 and go to WAIT.
  - WAIT: on mem_rsp_valid_i, push {req_addr, data}. Then go to REQ if credit is still available (req_addr ← fetch_pc), else go to IDLE.
  - DROP: on mem_rsp_valid_i, discard the data and go to IDLE.
- Credit: a new request may be issued only when count + (outstanding ? 1 : 0) < DEPTH, so a response never finds the queue full. There is no mem_rsp_ready.
- Request stability: once mem_req_valid_o is high, it and mem_req_addr_o hold until accepted, including across a redirect.
- Redirect, in every state:
  - The queue is emptied.
  - fetch_pc ← {redirect_pc_i[XLEN-1:2], 2'b00}.
  - State transition depends on the current state:
    - IDLE → IDLE.
    - WAIT → DROP.
    - DROP stays DROP.
    - REQ without handshake that cycle → REQ, with the redirected_pending flag set; on acceptance go to DROP.
    - REQ with handshake that cycle → DROP.
  - A response arriving in the same cycle as a redirect is discarded.
  - fetch_pc is not advanced by a dropped request.
- Pop: when inst_valid_o && inst_ready_i, advance the read pointer. Push and pop may occur in the same cycle; count is unchanged.
- Redirect combined with a pop in the same cycle: flush wins. IF/ID also flushes on redirect, so the pop is irrelevant.
- Address arithmetic is modulo 2^XLEN; 0xFFFF_FFFF_FFFF_FFFC+4 wraps to 0.

## Timing
- Reset values:
  - State IDLE, fetch_pc=RESET_PC, req_addr=0.
  - Queue empty, redirected_pending=0.
  - mem_req_valid_o=0, mem_req_addr_o=0.
  - inst_valid_o=0, inst_addr_o=0, inst_data_o=0.
  - Reset asserted mid-operation aborts everything immediately. A late response after release is not expected; the memory is reset together with this block.
- First request: mem_req_valid_o is high in the first cycle after the first rising edge following reset release.
- inst_valid_o is registered (count≠0). A response in cycle M gives inst_valid_o=1 in cycle M+1.
- With zero-wait memory (ready=1, response in the cycle after acceptance), a request is issued every 2 cycles. Steady throughput is 1 instruction per 2 cycles.
- Redirect in cycle N while IDLE or WAIT with no request pending:
  - From IDLE, mem_req_valid_o rises at N+2 with the new address: IDLE→REQ transition, then the request.
  - From WAIT, the redirect path goes through DROP first, which delays the new request until the stale response arrives.
- Outputs inst_addr_o and inst_data_o come from queue storage at the read pointer. They are stable while inst_valid_o && !inst_ready_i.

## Test plan
- Reset release, memory ready=1, 1-cycle response, inst_ready_i=1 → requests to 0x80000000, 0x80000004, 0x80000008. IF/ID sees the same addresses in order, with data matching the memory model.
- inst_ready_i=0 for 10 cycles → exactly 2 entries buffered. No third request is issued, and mem_req_valid_o stays 0 until a pop occurs.
- Redirect to 0x80001002 while in WAIT → the queue empties, the stale response is dropped, and the next request address is 0x80001000. No stale instruction reaches inst_valid_o.
- mem_req_ready_i=0 for 5 cycles with a redirect in cycle 2 → the address holds at the old value until accepted. Its response is dropped, and the next request goes to the redirect target.
- Redirect in the same cycle as mem_rsp_valid_i, and separately in the same cycle as a pop → no push occurs and the queue is empty the next cycle.
- Assert rst mid-WAIT with 1 entry queued → all outputs are 0 immediately. After release, fetch restarts at 0x80000000.
